acq_seq_ctrl: RTL
=================

Name: acq_seq_ctrl

Overview:
- Frame-acquisition sequencer in the clk_5m (adcclk) domain, placed between the PS control GPIOs and the g11620/adc9826 capture path.
- On a PS start it issues G11620 start pulses and waits for the AD9826 capture to finish each frame.
- Steers ADC RAM writes into alternating ping-pong banks of pldata RAM, raises a per-frame interrupt, and enforces a per-frame timeout.
- Replaces the static data-source mux feeding pldata RAM on the ADC path.

Parameters:
- ADDR_W, 10, ADC-side byte address width (one bank).
- DATA_W, 32, RAM data width.
- CNT_W, 16, width of gap and timeout counters.

Ports:
- clk  in  1  clk_5m
- rst_n  in  1  synchronous active-low reset
- start_in  in  1  PS start; rising edge detected internally
- stop_in  in  1  PS stop; level, sampled each cycle
- frame_num_in  in  8  frames per run; 0 = continuous
- gap_in  in  CNT_W  idle cycles between frames
- timeout_in  in  CNT_W  max cycles from sensor start to adc_done_in; 0 = disabled
- sensor_start_o  out  1  one-cycle pulse to g11620 start_in
- adc_done_in  in  1  one-cycle pulse from adc9826 at end of frame
- adc_ram_wr_in  in  1  ADC write strobe
- adc_ram_addr_in  in  ADDR_W  ADC byte address
- adc_ram_din  in  DATA_W  ADC write data
- ram_wr_o  out  1  pldata RAM write
- ram_addr_o  out  ADDR_W+1  {bank, addr}
- ram_din_o  out  DATA_W  pldata RAM data
- irq_o  out  1  frame-ready pulse
- bank_o  out  1  bank holding the last completed frame
- frame_cnt_o  out  8  frames completed in this run
- busy_o  out  1  high in any state except IDLE
- timeout_err_o  out  1  sticky; cleared by next accepted start

Behaviour:
- Reset values: every output 0; state IDLE; write bank 0.
- States:
  - IDLE: a start rising edge clears frame_cnt_o and timeout_err_o, sets write bank to 0, goes to TRIG. Start edges are ignored in any state other than IDLE.
  - TRIG: sensor_start_o=1 for exactly one cycle; load timeout counter; go to CAPT.
  - CAPT: forward ADC writes; exit on adc_done_in or timeout.
  - DONE: frame complete; then GAP or IDLE.
  - GAP: count gap_in cycles, then TRIG.
- Write path (CAPT only), registered, latency 1: ram_wr_o=adc_ram_wr_in, ram_addr_o={wbank, adc_ram_addr_in}, ram_din_o=adc_ram_din. Outside CAPT, ram_wr_o=0 and ADC writes are dropped.
- CAPT exit:
  - adc_done_in → DONE. A write arriving in the same cycle as adc_done_in is still forwarded.
  - Timeout counter reaching 0 when timeout_in≠0 → timeout_err_o=1, IDLE, no irq, frame_cnt_o unchanged.
- DONE (1 cycle):
  - irq_o=1 for one cycle; bank_o=wbank; wbank toggles; frame_cnt_o+1 (wraps at 255).
  - If frame_num_in≠0 and the new count equals frame_num_in → IDLE; else → GAP.
- GAP: gap_in=0 means TRIG on the next cycle.
- stop_in=1 in TRIG/GAP → IDLE next cycle.
- stop_in=1 in CAPT: the current frame is allowed to complete (through DONE), then → IDLE.
- frame_num_in and gap_in are sampled at each use; timeout_in is sampled in TRIG.
- rst_n low mid-run: immediate return to reset values; no write or irq issued that cycle.

Optional Feature:
- Macro ACQ_SEQ_CTRL_FRAME_HDR_EN.
- Defined: DONE is preceded by a one-cycle HDR state that writes {8'hA5, 8'h00, frame_cnt_o+1 zero-extended to 16} to {wbank, all-ones address with low two bits 0}. irq_o follows one cycle later than without the macro. ADC writes to that address are overwritten by the header.
- Undefined: no HDR state; the header address holds ADC data.

Decomposition:
- Package acq_seq_pkg holds:
  - the state enum;
  - HDR_MAGIC=8'hA5;
  - HDR_ADDR constant function of ADDR_W.
- One sub-module, acq_seq_cnt: a loadable down-counter with zero flag, instantiated twice (gap, timeout).

Test Plan:
- frame_num_in=3, gap_in=10, ADC writes 4 words per frame → 3 sensor_start_o pulses; RAM addresses 0x000–0x00C, then 0x400–0x40C, then 0x000–0x00C; 3 irq pulses with bank_o 0,1,0; busy_o drops after the third frame.
- frame_num_in=0, stop_in raised mid-CAPT of frame 2 → frame 2 completes, irq fires, frame_cnt_o=2, returns to IDLE.
- timeout_in=20, adc_done_in never arrives → timeout_err_o=1 at cycle 20 after TRIG, no irq; next start clears the flag.
- adc_done_in coincident with the final write to 0x3FC → write forwarded, irq issued one cycle later.
- Start edge while busy and a write outside CAPT → both ignored; ram_wr_o stays 0.
- With ACQ_SEQ_CTRL_FRAME_HDR_EN, first frame → write 0xA5000001 to 0x3FC, irq one cycle after that write.

Source files
------------

// File: rtl/acq_seq_pkg.sv
// Shared types and constants for the frame-acquisition sequencer.
package acq_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_TRIG = 3'd1,
        ST_CAPT = 3'd2,
        ST_HDR  = 3'd3,
        ST_DONE = 3'd4,
        ST_GAP  = 3'd5
    } acq_state_e;

    localparam logic [7:0] HDR_MAGIC = 8'hA5;

    // Header word sits at the last 32-bit-aligned byte address of a bank.
    function automatic logic [31:0] hdr_addr(input int addr_w);
        logic [31:0] all_ones_s;
        all_ones_s = (32'd1 << addr_w) - 32'd1;
        return all_ones_s & ~32'd3;
    endfunction

endpackage

// File: rtl/acq_seq_cnt.sv
// Loadable down-counter with zero flag; saturates at zero.
module acq_seq_cnt
    import acq_seq_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] cnt_r;

    // Count register: load has priority over decrement.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (en && (cnt_r != '0)) begin
            cnt_r <= cnt_r - W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = (cnt_r == '0);

endmodule

// File: rtl/acq_seq_ctrl.sv
// Frame-acquisition sequencer: sensor trigger, ping-pong RAM steering, irq, timeout.
// Optional ACQ_SEQ_CTRL_FRAME_HDR_EN inserts a frame-header write before DONE.
module acq_seq_ctrl
    import acq_seq_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_in,
    input  logic              stop_in,
    input  logic [7:0]        frame_num_in,
    input  logic [CNT_W-1:0]  gap_in,
    input  logic [CNT_W-1:0]  timeout_in,
    output logic              sensor_start_o,
    input  logic              adc_done_in,
    input  logic              adc_ram_wr_in,
    input  logic [ADDR_W-1:0] adc_ram_addr_in,
    input  logic [DATA_W-1:0] adc_ram_din,
    output logic              ram_wr_o,
    output logic [ADDR_W:0]   ram_addr_o,
    output logic [DATA_W-1:0] ram_din_o,
    output logic              irq_o,
    output logic              bank_o,
    output logic [7:0]        frame_cnt_o,
    output logic              busy_o,
    output logic              timeout_err_o
);

    localparam logic [ADDR_W-1:0] HDR_ADDR = ADDR_W'(hdr_addr(ADDR_W));

    acq_state_e        state_r, state_nx_s;
    logic              start_d_r, start_edge_s;
    logic              wbank_r, stop_pend_r, to_active_r;
    logic [7:0]        frame_cnt_r, cnt_inc_s;
    logic              to_fire_s, gap_zero_s, to_zero_s;
    logic              wr_nx_s, ram_wr_r;
    logic [ADDR_W:0]   addr_nx_s, ram_addr_r;
    logic [DATA_W-1:0] din_nx_s, ram_din_r, hdr_data_s;
    logic              sensor_start_r, irq_r, bank_r, busy_r, timeout_err_r;

    assign start_edge_s = start_in & ~start_d_r;
    assign cnt_inc_s    = frame_cnt_r + 8'd1;
    assign hdr_data_s   = DATA_W'({HDR_MAGIC, 8'h00, 8'h00, cnt_inc_s});

    acq_seq_cnt #(.W(CNT_W)) u_gap_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state_r == ST_DONE),
        .load_val (gap_in),
        .en       (state_r == ST_GAP),
        .zero     (gap_zero_s)
    );

    // Loaded with timeout_in-1 so the exit lands exactly timeout_in cycles after TRIG.
    acq_seq_cnt #(.W(CNT_W)) u_to_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state_r == ST_TRIG),
        .load_val (timeout_in - CNT_W'(1)),
        .en       (state_r == ST_CAPT),
        .zero     (to_zero_s)
    );

    // Next-state decode.
    always_comb begin
        state_nx_s = state_r;
        to_fire_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_edge_s) state_nx_s = ST_TRIG;
                else              state_nx_s = ST_IDLE;
            end
            ST_TRIG: begin
                if (stop_in) state_nx_s = ST_IDLE;
                else         state_nx_s = ST_CAPT;
            end
            ST_CAPT: begin
                if (adc_done_in) begin
`ifdef ACQ_SEQ_CTRL_FRAME_HDR_EN
                    state_nx_s = ST_HDR;
`else
                    state_nx_s = ST_DONE;
`endif
                end else if (to_active_r && to_zero_s) begin
                    state_nx_s = ST_IDLE;
                    to_fire_s  = 1'b1;
                end else begin
                    state_nx_s = ST_CAPT;
                end
            end
            ST_HDR:  state_nx_s = ST_DONE;
            ST_DONE: begin
                if (stop_pend_r || stop_in ||
                    ((frame_num_in != 8'd0) && (cnt_inc_s == frame_num_in)))
                    state_nx_s = ST_IDLE;
                else
                    state_nx_s = ST_GAP;
            end
            ST_GAP: begin
                if (stop_in)         state_nx_s = ST_IDLE;
                else if (gap_zero_s) state_nx_s = ST_TRIG;
                else                 state_nx_s = ST_GAP;
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // RAM write steering: ADC data in CAPT, header word in HDR, idle otherwise.
    always_comb begin
        wr_nx_s   = 1'b0;
        addr_nx_s = ram_addr_r;
        din_nx_s  = ram_din_r;
        if (state_r == ST_CAPT) begin
            wr_nx_s   = adc_ram_wr_in;
            addr_nx_s = {wbank_r, adc_ram_addr_in};
            din_nx_s  = adc_ram_din;
        end else if (state_r == ST_HDR) begin
            wr_nx_s   = 1'b1;
            addr_nx_s = {wbank_r, HDR_ADDR};
            din_nx_s  = hdr_data_s;
        end else begin
            wr_nx_s   = 1'b0;
        end
    end

    // State, run bookkeeping and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            start_d_r      <= 1'b0;
            wbank_r        <= 1'b0;
            stop_pend_r    <= 1'b0;
            to_active_r    <= 1'b0;
            frame_cnt_r    <= 8'd0;
            ram_wr_r       <= 1'b0;
            ram_addr_r     <= '0;
            ram_din_r      <= '0;
            sensor_start_r <= 1'b0;
            irq_r          <= 1'b0;
            bank_r         <= 1'b0;
            busy_r         <= 1'b0;
            timeout_err_r  <= 1'b0;
        end else begin
            state_r        <= state_nx_s;
            start_d_r      <= start_in;
            ram_wr_r       <= wr_nx_s;
            ram_addr_r     <= addr_nx_s;
            ram_din_r      <= din_nx_s;
            sensor_start_r <= (state_r == ST_TRIG);
            irq_r          <= (state_r == ST_DONE);
            busy_r         <= (state_nx_s != ST_IDLE);
            if (state_r == ST_TRIG) begin
                to_active_r <= (timeout_in != '0);
            end
            if ((state_r == ST_IDLE) && start_edge_s) begin
                frame_cnt_r   <= 8'd0;
                timeout_err_r <= 1'b0;
                wbank_r       <= 1'b0;
                stop_pend_r   <= 1'b0;
            end else if (state_r == ST_DONE) begin
                bank_r      <= wbank_r;
                wbank_r     <= ~wbank_r;
                frame_cnt_r <= cnt_inc_s;
                stop_pend_r <= 1'b0;
            end else if (state_r == ST_CAPT) begin
                if (stop_in)   stop_pend_r   <= 1'b1;
                if (to_fire_s) timeout_err_r <= 1'b1;
            end
        end
    end

    assign sensor_start_o = sensor_start_r;
    assign ram_wr_o       = ram_wr_r;
    assign ram_addr_o     = ram_addr_r;
    assign ram_din_o      = ram_din_r;
    assign irq_o          = irq_r;
    assign bank_o         = bank_r;
    assign frame_cnt_o    = frame_cnt_r;
    assign busy_o         = busy_r;
    assign timeout_err_o  = timeout_err_r;

endmodule
